// File: rtl/reg_file_pkg.sv
// Shared CPU constants for the RV32I pipeline: architectural register count,
// register index width, machine word width and the hard-wired zero register.
// Imported by the register file and any stage that decodes register indices.
package reg_file_pkg;

  localparam int          REG_COUNT      = 32;
  localparam int          REG_ADDR_WIDTH = 5;
  localparam int          XLEN           = 32;
  localparam logic [4:0]  ZERO_REG       = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Purpose: 32 x XLEN general-purpose register file, 2 combinational read ports,
//          1 synchronous write port; x0 is hard-wired to zero.
// Latency: reads 0 cycles (combinational); writes visible right after the CLK edge.
// Backpressure: none; a write is accepted on every rising edge with WRITE_ENABLE=1.
//
// Ports:
//   WRITE_DATA    - data written to the WRITE_ADDRESS register
//   DATA1/DATA2   - read port data, follow DATA1_ADDRESS/DATA2_ADDRESS combinationally
//   WRITE_ADDRESS - destination register index (writes to 0 are dropped)
//   DATA1_ADDRESS - read port 1 register index
//   DATA2_ADDRESS - read port 2 register index
//   WRITE_ENABLE  - active-high write strobe
//   CLK           - clock, writes on rising edge
//   RESET         - asynchronous active-low reset, clears all registers
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  output logic [DATA_WIDTH-1:0] DATA1,
  output logic [DATA_WIDTH-1:0] DATA2,
  input  logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  input  logic [ADDR_WIDTH-1:0] DATA1_ADDRESS,
  input  logic [ADDR_WIDTH-1:0] DATA2_ADDRESS,
  input  logic                  WRITE_ENABLE,
  input  logic                  CLK,
  input  logic                  RESET
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Writes to x0 are never performed, so regs[0] stays at its reset value of 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (WRITE_ENABLE && (WRITE_ADDRESS != ZERO_ADDR)) begin
      regs[WRITE_ADDRESS] <= WRITE_DATA;
    end
  end

  // No write-to-read bypass: the pipeline forwards around the register file.
  // The explicit zero compare lets synthesis drop the x0 storage entirely.
  always_comb begin
    DATA1 = (DATA1_ADDRESS == ZERO_ADDR) ? '0 : regs[DATA1_ADDRESS];
    DATA2 = (DATA2_ADDRESS == ZERO_ADDR) ? '0 : regs[DATA2_ADDRESS];
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, write/read, x0 protection,
// write disable, dual-port sweep, read-during-write and asynchronous reset.
module tb_reg_file;

  logic [31:0] WRITE_DATA;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  WRITE_ADDRESS;
  logic [4:0]  DATA1_ADDRESS;
  logic [4:0]  DATA2_ADDRESS;
  logic        WRITE_ENABLE;
  logic        CLK;
  logic        RESET;

  int total;
  int bad;

  reg_file dut (
    .WRITE_DATA    (WRITE_DATA),
    .DATA1         (DATA1),
    .DATA2         (DATA2),
    .WRITE_ADDRESS (WRITE_ADDRESS),
    .DATA1_ADDRESS (DATA1_ADDRESS),
    .DATA2_ADDRESS (DATA2_ADDRESS),
    .WRITE_ENABLE  (WRITE_ENABLE),
    .CLK           (CLK),
    .RESET         (RESET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one write cycle: set up after a falling edge, commit on the rising edge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic en);
    @(negedge CLK);
    WRITE_ADDRESS = addr;
    WRITE_DATA    = data;
    WRITE_ENABLE  = en;
    @(posedge CLK);
    #1;
    WRITE_ENABLE  = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd1; addrs[2] = 5'd31;
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      DATA1_ADDRESS = addrs[i];
      DATA2_ADDRESS = addrs[i];
      #1;
      total++;
      if (DATA1 !== 32'd0) begin
        bad++;
        $display("FAIL reset_d1 addr=%0d got=%h want=%h", addrs[i], DATA1, 32'd0);
      end
      total++;
      if (DATA2 !== 32'd0) begin
        bad++;
        $display("FAIL reset_d2 addr=%0d got=%h want=%h", addrs[i], DATA2, 32'd0);
      end
    end
  endtask

  task automatic test_write_read;
    DATA1_ADDRESS = 5'd0;
    @(negedge CLK);
    WRITE_ADDRESS = 5'd1;
    WRITE_DATA    = 32'd10;
    WRITE_ENABLE  = 1'b1;
    @(posedge CLK);
    #3;
    WRITE_ENABLE  = 1'b0;
    DATA1_ADDRESS = 5'd1;
    #3;
    total++;
    if (DATA1 !== 32'd10) begin
      bad++;
      $display("FAIL write_read got=%h want=%h", DATA1, 32'd10);
    end
  endtask

  task automatic test_x0;
    do_write(5'd0, 32'hDEADBEEF, 1'b1);
    DATA1_ADDRESS = 5'd0;
    DATA2_ADDRESS = 5'd0;
    #1;
    total++;
    if (DATA1 !== 32'd0) begin
      bad++;
      $display("FAIL x0_d1 got=%h want=%h", DATA1, 32'd0);
    end
    total++;
    if (DATA2 !== 32'd0) begin
      bad++;
      $display("FAIL x0_d2 got=%h want=%h", DATA2, 32'd0);
    end
  endtask

  task automatic test_write_disabled;
    do_write(5'd2, 32'd5, 1'b0);
    DATA1_ADDRESS = 5'd2;
    #1;
    total++;
    if (DATA1 !== 32'd0) begin
      bad++;
      $display("FAIL write_disabled got=%h want=%h", DATA1, 32'd0);
    end
    // A disabled cycle must not disturb an existing value either.
    do_write(5'd1, 32'hFFFF_FFFF, 1'b0);
    DATA1_ADDRESS = 5'd1;
    #1;
    total++;
    if (DATA1 !== 32'd10) begin
      bad++;
      $display("FAIL write_disabled_keep got=%h want=%h", DATA1, 32'd10);
    end
  endtask

  task automatic test_sweep;
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int i = 1; i < 32; i++) begin
      do_write(5'(i), 32'(i * 3), 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      DATA1_ADDRESS = 5'(i);
      DATA2_ADDRESS = 5'(31 - i);
      exp1 = (i == 0) ? 32'd0 : 32'(i * 3);
      exp2 = (i == 31) ? 32'd0 : 32'((31 - i) * 3);
      #1;
      total++;
      if (DATA1 !== exp1) begin
        bad++;
        $display("FAIL sweep_d1 addr=%0d got=%h want=%h", i, DATA1, exp1);
      end
      total++;
      if (DATA2 !== exp2) begin
        bad++;
        $display("FAIL sweep_d2 addr=%0d got=%h want=%h", 31 - i, DATA2, exp2);
      end
    end
    // Same register on both ports.
    DATA1_ADDRESS = 5'd17;
    DATA2_ADDRESS = 5'd17;
    #1;
    total++;
    if ((DATA1 !== 32'd51) || (DATA2 !== 32'd51)) begin
      bad++;
      $display("FAIL same_addr got=%h/%h want=%h", DATA1, DATA2, 32'd51);
    end
  endtask

  task automatic test_read_during_write;
    @(negedge CLK);
    DATA1_ADDRESS = 5'd9;
    WRITE_ADDRESS = 5'd9;
    WRITE_DATA    = 32'hCAFE_0009;
    WRITE_ENABLE  = 1'b1;
    #1;
    total++;
    if (DATA1 !== 32'd27) begin
      bad++;
      $display("FAIL rdw_before got=%h want=%h", DATA1, 32'd27);
    end
    @(posedge CLK);
    #1;
    WRITE_ENABLE = 1'b0;
    total++;
    if (DATA1 !== 32'hCAFE_0009) begin
      bad++;
      $display("FAIL rdw_after got=%h want=%h", DATA1, 32'hCAFE_0009);
    end
  endtask

  task automatic test_async_reset;
    do_write(5'd7, 32'h55, 1'b1);
    DATA1_ADDRESS = 5'd7;
    #1;
    total++;
    if (DATA1 !== 32'h55) begin
      bad++;
      $display("FAIL async_pre got=%h want=%h", DATA1, 32'h55);
    end
    // Assert reset between edges with a write pending; it must be lost.
    @(negedge CLK);
    WRITE_ADDRESS = 5'd7;
    WRITE_DATA    = 32'hAAAA;
    WRITE_ENABLE  = 1'b1;
    #1;
    RESET = 1'b0;
    #1;
    total++;
    if (DATA1 !== 32'd0) begin
      bad++;
      $display("FAIL async_zero got=%h want=%h", DATA1, 32'd0);
    end
    @(posedge CLK);
    #1;
    total++;
    if (DATA1 !== 32'd0) begin
      bad++;
      $display("FAIL async_write_lost got=%h want=%h", DATA1, 32'd0);
    end
    WRITE_ENABLE = 1'b0;
    DATA2_ADDRESS = 5'd31;
    #1;
    total++;
    if (DATA2 !== 32'd0) begin
      bad++;
      $display("FAIL async_other got=%h want=%h", DATA2, 32'd0);
    end
    @(negedge CLK);
    RESET = 1'b1;
    // First edge after release accepts a write.
    do_write(5'd7, 32'h1234_5678, 1'b1);
    #1;
    total++;
    if (DATA1 !== 32'h1234_5678) begin
      bad++;
      $display("FAIL first_write_after_reset got=%h want=%h", DATA1, 32'h1234_5678);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET         = 1'b0;
    WRITE_DATA    = '0;
    WRITE_ADDRESS = '0;
    DATA1_ADDRESS = '0;
    DATA2_ADDRESS = '0;
    WRITE_ENABLE  = 1'b0;
    test_reset();
    test_write_read();
    test_x0();
    test_write_disabled();
    test_sweep();
    test_read_during_write();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file
